// File: rtl/mem_arbiter.sv
// Arbiter sharing one SRAM port between instruction fetch and load/store.
// Load/store has priority; a streak counter guarantees fetch forward progress.
module mem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk_i,
    input  logic        rts_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_done_o,
    output logic [31:0] if_rdata_o,
    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [31:0] ls_addr_i,
    input  logic [1:0]  ls_size_i,
    input  logic [31:0] ls_wdata_i,
    output logic        ls_done_o,
    output logic [31:0] ls_rdata_o,
    output logic [31:0] mem_addr_o,
    output logic [1:0]  mem_size_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_rwr_o,
    output logic        mem_cs_n_o,
    input  logic [31:0] mem_rdata_i
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STK_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [STK_W-1:0]   streak_q;
    logic               owner_ls_q;
    logic               we_q;
    logic               if_done_q;
    logic               ls_done_q;
    logic [31:0]        if_rdata_q;
    logic [31:0]        ls_rdata_q;
    logic [31:0]        mem_addr_q;
    logic [1:0]         mem_size_q;
    logic [31:0]        mem_wdata_q;
    logic               mem_rwr_q;
    logic               mem_cs_n_q;

    logic               grant_ls_d;
    logic [1:0]         ls_size_d;
    logic [STK_W-1:0]   streak_d;

    // Winner selection, LS size mapping and the streak value to commit on a grant.
    always_comb begin
        grant_ls_d = ls_req_i && (!if_req_i || (streak_q != STK_MAX));
        ls_size_d  = (ls_size_i == 2'd2) ? 2'd3 : ls_size_i;
        streak_d   = '0;
        if (!grant_ls_d || !if_req_i) begin
            streak_d = '0;
        end else if (streak_q == STK_MAX) begin
            streak_d = streak_q;
        end else begin
            streak_d = streak_q + STK_W'(1);
        end
    end

    // Access FSM with all SRAM-side and requester-side outputs registered.
    always_ff @(posedge clk_i) begin
        if (rts_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            streak_q    <= '0;
            owner_ls_q  <= 1'b0;
            we_q        <= 1'b0;
            if_done_q   <= 1'b0;
            ls_done_q   <= 1'b0;
            if_rdata_q  <= 32'd0;
            ls_rdata_q  <= 32'd0;
            mem_addr_q  <= 32'd0;
            mem_size_q  <= 2'd3;
            mem_wdata_q <= 32'd0;
            mem_rwr_q   <= 1'b1;
            mem_cs_n_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if_done_q <= 1'b0;
                    ls_done_q <= 1'b0;
                    if (ls_req_i || if_req_i) begin
                        state_q    <= ST_BUSY;
                        cnt_q      <= CNT_INIT;
                        streak_q   <= streak_d;
                        owner_ls_q <= grant_ls_d;
                        mem_cs_n_q <= 1'b0;
                        // The mem_* registers double as the latched request fields.
                        if (grant_ls_d) begin
                            mem_addr_q  <= ls_addr_i;
                            mem_size_q  <= ls_size_d;
                            mem_wdata_q <= ls_wdata_i;
                            we_q        <= ls_we_i;
                            mem_rwr_q   <= ~ls_we_i;
                        end else begin
                            mem_addr_q  <= if_addr_i;
                            mem_size_q  <= 2'd3;
                            mem_wdata_q <= mem_wdata_q;
                            we_q        <= 1'b0;
                            mem_rwr_q   <= 1'b1;
                        end
                    end else begin
                        mem_cs_n_q <= 1'b1;
                        mem_rwr_q  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == '0) begin
                        state_q    <= ST_DONE;
                        mem_cs_n_q <= 1'b1;
                        mem_rwr_q  <= 1'b1;
                        if (owner_ls_q) begin
                            ls_done_q <= 1'b1;
                            if (!we_q) begin
                                ls_rdata_q <= mem_rdata_i;
                            end else begin
                                ls_rdata_q <= ls_rdata_q;
                            end
                        end else begin
                            if_done_q  <= 1'b1;
                            if_rdata_q <= mem_rdata_i;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if_done_q <= 1'b0;
                    ls_done_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    if_done_q  <= 1'b0;
                    ls_done_q  <= 1'b0;
                    mem_cs_n_q <= 1'b1;
                    mem_rwr_q  <= 1'b1;
                end
            endcase
        end
    end

    assign if_done_o   = if_done_q;
    assign ls_done_o   = ls_done_q;
    assign if_rdata_o  = if_rdata_q;
    assign ls_rdata_o  = ls_rdata_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_size_o  = mem_size_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_rwr_o   = mem_rwr_q;
    assign mem_cs_n_o  = mem_cs_n_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected owner/data queued at issue,
// popped and compared on every done pulse.
module tb_mem_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 3;

    logic        clk;
    logic        rts;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [1:0]  ls_size;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic [31:0] mem_wdata;
    logic        mem_rwr;
    logic        mem_cs_n;
    logic [31:0] mem_rdata;

    typedef struct packed {
        logic        ls;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [1:0]  prev_done;
    logic [31:0] exp_if;
    logic [31:0] exp_ls;
    int          err_cnt;
    int          chk_cnt;

    mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_i      (clk),
        .rts_i      (rts),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_done_o  (if_done),
        .if_rdata_o (if_rdata),
        .ls_req_i   (ls_req),
        .ls_we_i    (ls_we),
        .ls_addr_i  (ls_addr),
        .ls_size_i  (ls_size),
        .ls_wdata_i (ls_wdata),
        .ls_done_o  (ls_done),
        .ls_rdata_o (ls_rdata),
        .mem_addr_o (mem_addr),
        .mem_size_o (mem_size),
        .mem_wdata_o(mem_wdata),
        .mem_rwr_o  (mem_rwr),
        .mem_cs_n_o (mem_cs_n),
        .mem_rdata_i(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
        else return {a[15:0], ~a[15:0]};
    endfunction

    assign mem_rdata = memf(mem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done pulse must be single-cycle and match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rts && (if_done || ls_done)) begin
            chk("done_width", {30'd0, prev_done}, 32'd0);
            chk("done_both", {31'd0, if_done & ls_done}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexp_done", {30'd0, if_done, ls_done}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("owner", {31'd0, ls_done}, {31'd0, mon_e.ls});
                chk("rdata", mon_e.ls ? ls_rdata : if_rdata, mon_e.data);
            end
        end
        prev_done <= {if_done, ls_done};
    end

    task automatic run_req(input logic is_ls, input logic we, input logic [31:0] addr,
                           input logic [1:0] size, input logic [31:0] wdata, input logic perturb);
        logic [1:0]  esz;
        logic [31:0] ed;
        esz = (!is_ls || size == 2'd2) ? 2'd3 : size;
        if (is_ls) begin
            ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_size = size; ls_wdata = wdata;
            if (!we) exp_ls = memf(addr);
            ed = exp_ls;
        end else begin
            if_req = 1'b1; if_addr = addr;
            exp_if = memf(addr);
            ed = exp_if;
        end
        exp_q.push_back({is_ls, ed});
        chk("idle_cs", {31'd0, mem_cs_n}, 32'd1);
        for (int i = 0; i < MEM_LAT; i++) begin
            tick();
            chk("busy_cs", {31'd0, mem_cs_n}, 32'd0);
            chk("busy_addr", mem_addr, addr);
            chk("busy_size", {30'd0, mem_size}, {30'd0, esz});
            chk("busy_rwr", {31'd0, mem_rwr}, {31'd0, (is_ls ? ~we : 1'b1)});
            if (is_ls && we) chk("busy_wdata", mem_wdata, wdata);
            if (perturb) begin
                ls_addr = ~addr; ls_wdata = ~wdata; ls_size = 2'd0;
            end
        end
        tick();
        chk("done_pulse", {31'd0, (is_ls ? ls_done : if_done)}, 32'd1);
        chk("done_cs", {31'd0, mem_cs_n}, 32'd1);
        chk("done_rwr", {31'd0, mem_rwr}, 32'd1);
        if (is_ls) ls_req = 1'b0;
        else if_req = 1'b0;
        tick();
        chk("idle_nodone", {30'd0, if_done, ls_done}, 32'd0);
    endtask

    task automatic wait_done(output int cyc, input logic drop);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!(if_done || ls_done) && cyc < 50);
        chk("timeout", {31'd0, if_done | ls_done}, 32'd1);
        if (drop) begin
            if (if_done) if_req = 1'b0;
            if (ls_done) ls_req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        logic [31:0] mark;
        err_cnt = 0; chk_cnt = 0;
        exp_if = 32'd0; exp_ls = 32'd0;
        rts = 1'b1; if_req = 1'b0; if_addr = 32'd0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = 32'd0; ls_size = 2'd0; ls_wdata = 32'd0;
        tick();
        tick();
        chk("rst_cs", {31'd0, mem_cs_n}, 32'd1);
        chk("rst_rwr", {31'd0, mem_rwr}, 32'd1);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_size", {30'd0, mem_size}, 32'd3);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", if_rdata | ls_rdata, 32'd0);
        chk("rst_done", {30'd0, if_done, ls_done}, 32'd0);
        rts = 1'b0;
        tick();

        // Fetch, store, perturbed load, byte load.
        run_req(1'b0, 1'b0, 32'h0000_0010, 2'd2, 32'd0, 1'b0);
        chk("if_rdata_hold", if_rdata, 32'hDEAD_BEEF);
        run_req(1'b1, 1'b1, 32'h0000_0040, 2'd2, 32'h1234_5678, 1'b0);
        chk("store_ls_rdata", ls_rdata, 32'd0);
        run_req(1'b1, 1'b0, 32'h0000_0A00, 2'd1, 32'h5555_AAAA, 1'b1);
        run_req(1'b1, 1'b0, 32'h0000_0123, 2'd0, 32'd0, 1'b0);

        // Fetch arrives mid-load: served only after the load completes.
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0300; ls_size = 2'd1;
        exp_ls = memf(32'h0000_0300);
        exp_q.push_back({1'b1, exp_ls});
        tick();
        if_req = 1'b1; if_addr = 32'h0000_0104;
        exp_if = memf(32'h0000_0104);
        exp_q.push_back({1'b0, exp_if});
        wait_done(cyc, 1'b1);
        chk("mid_ls_first", {31'd0, ls_done}, 32'd1);
        chk("mid_ls_lat", cyc, MEM_LAT);
        wait_done(cyc, 1'b1);
        chk("mid_if_second", {31'd0, if_done}, 32'd1);
        chk("mid_if_lat", cyc, MEM_LAT + 2);
        tick();

        // Both requesting continuously: starvation guard ordering.
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0200; ls_size = 2'd2;
        if_req = 1'b1; if_addr = 32'h0000_0100;
        exp_ls = memf(32'h0000_0200);
        exp_if = memf(32'h0000_0100);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({(i % 4) != 3, ((i % 4) != 3) ? exp_ls : exp_if});
        end
        for (int i = 0; i < 8; i++) begin
            wait_done(cyc, 1'b0);
            chk("b2b_lat", cyc, (i == 0) ? MEM_LAT + 1 : MEM_LAT + 2);
        end
        ls_req = 1'b0; if_req = 1'b0;
        tick();
        tick();

        // Reset during the second BUSY cycle of a load aborts it.
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0080; ls_size = 2'd2;
        tick();
        tick();
        rts = 1'b1;
        tick();
        rts = 1'b0; ls_req = 1'b0;
        exp_if = 32'd0; exp_ls = 32'd0;
        chk("abort_cs", {31'd0, mem_cs_n}, 32'd1);
        chk("abort_ls_rdata", ls_rdata, 32'd0);
        chk("abort_if_rdata", if_rdata, 32'd0);
        chk("abort_done", {30'd0, if_done, ls_done}, 32'd0);
        mark = 32'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            mark = mark | {30'd0, if_done, ls_done};
        end
        chk("abort_nodone", mark, 32'd0);
        run_req(1'b1, 1'b0, 32'h0000_0084, 2'd2, 32'd0, 1'b0);

        tick();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
